// File: rtl/dsp_pkg.sv
// dsp_pkg
//   Shared constants for the dsp equalizer path: BER checker state encoding
//   and the PRBS9 (x^9 + x^5 + 1) seed and tap positions. The transmit-side
//   PRBS generator in the channel model uses the same constants, so both
//   ends of the link agree on the sequence.
package dsp_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } ber_state_t;

  localparam logic [8:0] PRBS9_SEED  = 9'h1FF;
  // Feedback taps into the 9-bit state register (x^9 and x^5 terms).
  localparam int         PRBS9_TAP_A = 8;
  localparam int         PRBS9_TAP_B = 4;

endpackage

// File: rtl/ber_checker_prbs9_gen.sv
// prbs9_gen
//   PRBS9 reference generator, x^9 + x^5 + 1. The output bit is the feedback
//   value of the current state and is shifted in on every enabled cycle.
//   Ports:
//     i_clk  dsp clock
//     i_rst  asynchronous active-high reset, loads the seed
//     i_en   advance strobe; the state holds when low
//     o_bit  current reference bit
module prbs9_gen
  import dsp_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_bit
);

  logic [8:0] prbs;

  assign o_bit = prbs[PRBS9_TAP_A] ^ prbs[PRBS9_TAP_B];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prbs <= PRBS9_SEED;
    end else if (i_en) begin
      prbs <= {prbs[7:0], o_bit};
    end
  end

endmodule

// File: rtl/ber_checker.sv
// ber_checker
//   Compares slicer decisions against a local PRBS9 reference. After filling
//   the reference delay line it searches candidate latencies one window at a
//   time, locks on a clean window, then accumulates saturating error and bit
//   counts until a bad window sends it back to searching.
//   Ports:
//     i_clk      dsp clock (clockdsp)
//     i_rst      asynchronous active-high reset
//     i_en       symbol strobe
//     i_bit      slicer decision (1 => PRBS bit 1)
//     i_clear    synchronous clear of counters, sticky sat and window
//     o_locked   high in LOCKED
//     o_delay    current candidate / locked latency in enables
//     o_err_cnt  accumulated errors while locked
//     o_bit_cnt  accumulated compared bits while locked
//     o_sat      sticky, set when either counter reaches all-ones
//     o_state    FSM state for debug visibility
//
// Handshake: i_en is a valid-only strobe. A symbol is consumed on every
// rising clock edge where i_en=1; there is no backpressure, and with i_en=0
// nothing advances (i_clear still acts).
module ber_checker
  import dsp_pkg::*;
#(
  parameter int MAX_DELAY  = 64,
  parameter int WIN_LEN    = 1024,
  parameter int LOCK_THR   = 8,
  parameter int UNLOCK_THR = 256,
  parameter int CNT_BW     = 48
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_en,
  input  logic                         i_bit,
  input  logic                         i_clear,
  output logic                         o_locked,
  output logic [$clog2(MAX_DELAY)-1:0] o_delay,
  output logic [CNT_BW-1:0]            o_err_cnt,
  output logic [CNT_BW-1:0]            o_bit_cnt,
  output logic                         o_sat,
  output logic [1:0]                   o_state
);

  localparam int DW = $clog2(MAX_DELAY);
  localparam int WW = $clog2(WIN_LEN);
  localparam int EW = $clog2(WIN_LEN + 1);
  localparam logic [CNT_BW-1:0] CNT_MAX = '1;

  ber_state_t          state_q, state_d;
  logic [DW-1:0]       delay_d;
  logic [DW-1:0]       fill_cnt;
  logic [WW-1:0]       win_cnt;
  logic [EW-1:0]       win_err;
  logic [MAX_DELAY-2:0] dline;
  logic [MAX_DELAY-1:0] taps;
  logic                ref_bit;
  logic                err;
  logic                sample;
  logic                win_last;
  logic [EW-1:0]       win_total;
  logic [DW-1:0]       next_delay;
  logic [CNT_BW-1:0]   bit_inc;
  logic [CNT_BW-1:0]   err_inc;

  prbs9_gen u_prbs (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (i_en),
    .o_bit (ref_bit)
  );

  // taps[k] is the reference produced k enables ago; taps[0] is the current one.
  assign taps = {dline, ref_bit};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dline <= '0;
    end else if (i_en) begin
      dline <= taps[MAX_DELAY-2:0];
    end
  end

  assign err        = i_bit ^ taps[o_delay];
  // A cleared sample still moves the reference but is kept out of all counts.
  assign sample     = i_en && !i_clear && (state_q != ST_FILL);
  assign win_last   = (win_cnt == WW'(WIN_LEN - 1));
  assign win_total  = win_err + EW'(err);
  assign next_delay = (o_delay == DW'(MAX_DELAY - 1)) ? '0 : o_delay + 1'b1;
  assign bit_inc    = (o_bit_cnt == CNT_MAX) ? o_bit_cnt : o_bit_cnt + 1'b1;
  assign err_inc    = (err && (o_err_cnt != CNT_MAX)) ? o_err_cnt + 1'b1 : o_err_cnt;

  always_comb begin
    state_d = state_q;
    delay_d = o_delay;
    case (state_q)
      ST_FILL: begin
        if (i_en && (fill_cnt == DW'(MAX_DELAY - 1))) begin
          state_d = ST_SEARCH;
          delay_d = '0;
        end
      end
      ST_SEARCH: begin
        if (sample && win_last) begin
          if (win_total < EW'(LOCK_THR)) state_d = ST_LOCKED;
          else                           delay_d = next_delay;
        end
      end
      ST_LOCKED: begin
        if (sample && win_last && (win_total >= EW'(UNLOCK_THR))) begin
          state_d = ST_SEARCH;
          delay_d = next_delay;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_FILL;
      o_delay   <= '0;
      fill_cnt  <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      o_err_cnt <= '0;
      o_bit_cnt <= '0;
      o_sat     <= 1'b0;
    end else begin
      state_q <= state_d;
      o_delay <= delay_d;
      if (i_en && (state_q == ST_FILL)) fill_cnt <= fill_cnt + 1'b1;
      if (i_clear) begin
        win_cnt   <= '0;
        win_err   <= '0;
        o_err_cnt <= '0;
        o_bit_cnt <= '0;
        o_sat     <= 1'b0;
      end else if (sample) begin
        win_cnt <= win_last ? '0 : win_cnt + 1'b1;
        win_err <= win_last ? '0 : win_total;
        if (state_q == ST_LOCKED) begin
          o_bit_cnt <= bit_inc;
          o_err_cnt <= err_inc;
          if ((bit_inc == CNT_MAX) || (err_inc == CNT_MAX)) o_sat <= 1'b1;
        end
      end
    end
  end

  assign o_locked = (state_q == ST_LOCKED);
  assign o_state  = state_q;

endmodule

// File: tb/tb_ber_checker.sv
// tb_ber_checker
//   Self-checking bench for ber_checker. Two instances share one stimulus:
//   a wide-counter one and an 8-bit-counter one for saturation. Window and
//   delay-line sizes are reduced to keep the run short.
module tb_ber_checker;

  localparam int MD  = 16;
  localparam int WL  = 128;
  localparam int LT  = 8;
  localparam int UT  = 32;
  localparam int BW  = 48;
  localparam int DLY = 5;
  localparam int DW  = $clog2(MD);
  localparam int FILL_MODE   = 0;
  localparam int SEARCH_MODE = 1;
  localparam int LOCK_MODE   = 2;
  localparam longint CAP   = (64'd1 << BW) - 1;
  localparam longint CAP8  = 255;
  localparam int LOCK_ENS  = MD + 6 * WL;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst, en, bt, clr;
  always #5 clk = ~clk;

  logic          locked, locked8, sat, sat8;
  logic [DW-1:0] delay, delay8;
  logic [BW-1:0] errc, bitc;
  logic [7:0]    errc8, bitc8;
  logic [1:0]    st, st8;

  ber_checker #(.MAX_DELAY(MD), .WIN_LEN(WL), .LOCK_THR(LT), .UNLOCK_THR(UT), .CNT_BW(BW)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_bit(bt), .i_clear(clr),
    .o_locked(locked), .o_delay(delay), .o_err_cnt(errc), .o_bit_cnt(bitc),
    .o_sat(sat), .o_state(st)
  );

  ber_checker #(.MAX_DELAY(MD), .WIN_LEN(WL), .LOCK_THR(LT), .UNLOCK_THR(UT), .CNT_BW(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_bit(bt), .i_clear(clr),
    .o_locked(locked8), .o_delay(delay8), .o_err_cnt(errc8), .o_bit_cnt(bitc8),
    .o_sat(sat8), .o_state(st8)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Expected PRBS9 bit stream: s[k] = s[k-9] ^ s[k-5], seeded with nine ones.
  // The reference for enable n (counted from reset) is exp_q[n+9].
  logic [0:0] exp_q[$];

  function automatic logic ref_at(int idx);
    while (exp_q.size() <= idx + 9)
      exp_q.push_back(exp_q[exp_q.size() - 9] ^ exp_q[exp_q.size() - 5]);
    return exp_q[idx + 9];
  endfunction

  // Behavioural model state.
  int     m_en, m_mode, m_delay, m_wpos, m_werr;
  longint m_err, m_bits, m_err8, m_bits8;
  bit     m_sat, m_sat8;

  function automatic longint sat_add(longint v, longint a, longint cap);
    return (v + a > cap) ? cap : v + a;
  endfunction

  function automatic void model_reset();
    m_en = 0; m_mode = FILL_MODE; m_delay = 0; m_wpos = 0; m_werr = 0;
    m_err = 0; m_bits = 0; m_sat = 0; m_err8 = 0; m_bits8 = 0; m_sat8 = 0;
  endfunction

  function automatic void model_step(bit e, bit c, bit b);
    bit e_bit;
    int tot;
    if (c) begin
      m_wpos = 0; m_werr = 0;
      m_err = 0; m_bits = 0; m_sat = 0; m_err8 = 0; m_bits8 = 0; m_sat8 = 0;
    end
    if (!e) return;
    if (m_mode == FILL_MODE) begin
      if (m_en == MD - 1) begin m_mode = SEARCH_MODE; m_delay = 0; end
    end else if (!c) begin
      e_bit = b ^ ref_at(m_en - m_delay);
      tot   = m_werr + int'(e_bit);
      if (m_mode == LOCK_MODE) begin
        m_bits  = sat_add(m_bits, 1, CAP);
        m_err   = sat_add(m_err, longint'(e_bit), CAP);
        m_bits8 = sat_add(m_bits8, 1, CAP8);
        m_err8  = sat_add(m_err8, longint'(e_bit), CAP8);
        if (m_bits == CAP || m_err == CAP) m_sat = 1;
        if (m_bits8 == CAP8 || m_err8 == CAP8) m_sat8 = 1;
      end
      if (m_wpos == WL - 1) begin
        if (m_mode == SEARCH_MODE && tot < LT) begin
          m_mode = LOCK_MODE;
        end else if (m_mode == SEARCH_MODE || tot >= UT) begin
          m_mode  = SEARCH_MODE;
          m_delay = (m_delay + 1) % MD;
        end
        m_wpos = 0; m_werr = 0;
      end else begin
        m_wpos++;
        m_werr = tot;
      end
    end
    m_en++;
  endfunction

  function automatic logic dly_bit();
    return (m_en >= DLY) ? ref_at(m_en - DLY) : 1'b0;
  endfunction

  task automatic compare_all(input string w);
    check({w, ".state"},   64'(st),     64'(m_mode));
    check({w, ".locked"},  64'(locked), 64'(m_mode == LOCK_MODE));
    check({w, ".delay"},   64'(delay),  64'(m_delay));
    check({w, ".err"},     64'(errc),   64'(m_err));
    check({w, ".bits"},    64'(bitc),   64'(m_bits));
    check({w, ".sat"},     64'(sat),    64'(m_sat));
    check({w, ".state8"},  64'(st8),    64'(m_mode));
    check({w, ".delay8"},  64'(delay8), 64'(m_delay));
    check({w, ".err8"},    64'(errc8),  64'(m_err8));
    check({w, ".bits8"},   64'(bitc8),  64'(m_bits8));
    check({w, ".sat8"},    64'(sat8),   64'(m_sat8));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic e, input logic c, input logic b);
    int pm, pd;
    en = e; clr = c; bt = b;
    pm = m_mode; pd = m_delay;
    @(posedge clk);
    model_step(e, c, b);
    #1;
    cyc++;
    if (m_mode != pm || m_delay != pd || (cyc % 50) == 0) compare_all("track");
  endtask

  task automatic do_reset();
    en = 0; clr = 0; bt = 0; rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic run_to_lock(input string w, input int gap);
    for (int k = 0; k < LOCK_ENS; k++) begin
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      if (k == LOCK_ENS - 1) check({w, ".prelock"}, 64'(locked), 64'd0);
      step(1'b1, 1'b0, dly_bit());
    end
    check({w, ".locked"}, 64'(locked), 64'd1);
    check({w, ".delay"},  64'(delay),  64'(DLY));
    check({w, ".err0"},   64'(errc),   64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ever_locked;
    int pre;
    exp_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back(1'b1);
    model_reset();
    rst = 1; en = 0; clr = 0; bt = 0;
    #1;
    compare_all("reset");
    do_reset();
    compare_all("post_reset");

    // Clean delayed PRBS, continuous enable.
    run_to_lock("s1", 0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, dly_bit());
    check("s1.bits10", 64'(bitc), 64'd10);
    compare_all("s1.end");

    // Clear, then every 100th bit flipped over 10000 symbols with random idles.
    step(1'b1, 1'b1, dly_bit());
    check("s2.clr_err",  64'(errc), 64'd0);
    check("s2.clr_bits", 64'(bitc), 64'd0);
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(0, 7) == 0) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      step(1'b1, 1'b0, dly_bit() ^ 1'(k % 100 == 99));
    end
    check("s2.err",    64'(errc),   64'd100);
    check("s2.bits",   64'(bitc),   64'd10000);
    check("s2.locked", 64'(locked), 64'd1);
    check("s2.sat",    64'(sat),    64'd0);
    check("s5.bits8",  64'(bitc8),  64'd255);
    check("s5.err8",   64'(errc8),  64'd100);
    check("s5.sat8",   64'(sat8),   64'd1);
    compare_all("s2.end");

    // Clear together with an enable: counters and sat drop, sample not counted.
    step(1'b1, 1'b1, dly_bit() ^ 1'b1);
    check("s5.clr_bits8", 64'(bitc8), 64'd0);
    check("s5.clr_err8",  64'(errc8), 64'd0);
    check("s5.clr_sat8",  64'(sat8),  64'd0);
    check("s5.clr_bits",  64'(bitc),  64'd0);
    step(1'b1, 1'b0, dly_bit());
    check("s5.bits_after", 64'(bitc8), 64'd1);
    check("s5.lock_kept",  64'(locked), 64'd1);

    // Async reset in the middle of LOCKED, then relock.
    pre = $urandom_range(1, 60);
    for (int k = 0; k < pre; k++) step(1'b1, 1'b0, dly_bit());
    #2 rst = 1;
    #1;
    check("s6.async_locked", 64'(locked), 64'd0);
    check("s6.async_err",    64'(errc),   64'd0);
    check("s6.async_bits",   64'(bitc),   64'd0);
    check("s6.async_delay",  64'(delay),  64'd0);
    check("s6.async_state",  64'(st),     64'(FILL_MODE));
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    run_to_lock("s6", 0);

    // Enable one cycle in three: lock at the same enable count.
    do_reset();
    run_to_lock("s4", 2);
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      check("s4.idle_bits", 64'(bitc), 64'(m_bits));
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      step(1'b1, 1'b0, dly_bit());
    end
    check("s4.bits30", 64'(bitc), 64'd30);

    // Independent random input: never locks, delay steps per window and wraps.
    do_reset();
    ever_locked = 0;
    for (int k = 0; k < MD + 17 * WL; k++) begin
      step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
      if (locked) ever_locked = 1;
      if (k + 1 == MD + 15 * WL) check("s3.delay15", 64'(delay), 64'd15);
      if (k + 1 == MD + 16 * WL) check("s3.wrap0",   64'(delay), 64'd0);
    end
    check("s3.never_locked", 64'(ever_locked), 64'd0);
    check("s3.delay1",       64'(delay),       64'd1);
    compare_all("s3.end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ber_checker.md
Name: ber_checker

Overview:
Downstream of the slicer in the dsp equalizer path. Consumes one hard decision per enabled symbol and compares it against a locally generated PRBS9 reference. It searches for the channel+FFE latency, locks, then accumulates error and bit counts for BER readout over the register file. It is also a loggable source for the bram logger.

Parameters:
MAX_DELAY, 64, depth of the reference delay line; candidate latencies are 0..MAX_DELAY-1.
WIN_LEN, 1024, enabled symbols per evaluation window.
LOCK_THR, 8, lock is declared when window errors < LOCK_THR.
UNLOCK_THR, 256, lock is dropped when window errors >= UNLOCK_THR.
CNT_BW, 48, width of the accumulated error and bit counters.

Ports:
i_clk  in  1  dsp clock (clockdsp).
i_rst  in  1  asynchronous active-high reset (soft_reset).
i_en  in  1  symbol enable, same strobe that drives ffe/lms (rf_enables_module[0]).
i_bit  in  1  slicer decision = ffe_out sign bit (1 => -1 => PRBS bit 1).
i_clear  in  1  synchronous clear of counters and window.
o_locked  out  1  high in LOCKED state.
o_delay  out  clog2(MAX_DELAY)  current candidate/locked latency.
o_err_cnt  out  CNT_BW  accumulated errors while locked.
o_bit_cnt  out  CNT_BW  accumulated compared bits while locked.
o_sat  out  1  sticky; set when either counter saturates.

Behaviour:
- Reset (async, i_rst=1):
  - PRBS state = 9'h1FF; delay line = 0; fill counter = 0.
  - Window counter and window errors = 0; state = FILL.
  - All outputs 0.
- Advance rule: all state advances only on cycles with i_en=1. With i_en=0 every register holds.
- Reference generator: PRBS9, x^9+x^5+1.
  - ref = prbs[8]^prbs[4].
  - prbs <= {prbs[7:0], ref} each enable.
  - Delay line shifts ref in each enable.
- Candidate reference bit: the ref generated o_delay enables earlier (delay 0 = current ref).
- Compare: err = i_bit ^ candidate bit.
- FILL: counts MAX_DELAY enables, no comparison. Then go to SEARCH with o_delay = 0.
- SEARCH: accumulate window errors over WIN_LEN enables. On the last sample, evaluate the total including that sample:
  - If total < LOCK_THR: go to LOCKED; o_delay holds.
  - Otherwise: o_delay+1, wrapping MAX_DELAY-1 -> 0.
  - In both cases the window restarts.
- LOCKED, each enable:
  - o_bit_cnt += 1.
  - o_err_cnt += err.
  - Both counters saturate at all-ones; o_sat is set in the same cycle either one reaches all-ones.
  - At window end, if window errors >= UNLOCK_THR: go to SEARCH with o_delay+1 (wrapping). o_err_cnt and o_bit_cnt hold their values.
- Latency: counters, o_locked and o_delay are registered and update on the clock edge of the enabled sample. They are visible the next cycle.
- i_clear:
  - Zeros o_err_cnt, o_bit_cnt, o_sat, window counter and window errors.
  - State, o_delay and the PRBS are untouched.
  - If i_clear and i_en are both high, clear wins and that sample is neither counted nor windowed; PRBS and delay line still advance.
- Reset mid-operation: immediate return to FILL from any state; the counters are lost.
- Widths:
  - Window counter is clog2(WIN_LEN) bits.
  - Window error counter is clog2(WIN_LEN+1) bits; it cannot overflow.

Decomposition:
- Shared package dsp_pkg: state encoding (ST_FILL, ST_SEARCH, ST_LOCKED), PRBS9 seed 9'h1FF and tap positions.
- The transmit-side PRBS generator in the channel model uses the same package constants.
- One sub-module: prbs9_gen (i_clk, i_rst, i_en, o_bit). It is reused by the channel stimulus.

Test Plan:
1. i_bit = PRBS9 delayed 5 enables, i_en=1 continuous.
   - o_locked rises after 64 + 6*1024 enables, with o_delay=5.
   - o_err_cnt stays 0; o_bit_cnt increments by 1 per cycle.
2. Locked at delay 5, flip every 100th i_bit for 10000 symbols.
   - o_err_cnt = 100 and o_bit_cnt = 10000.
   - o_locked stays 1.
3. i_bit from an independent LFSR.
   - o_locked never rises.
   - o_delay steps once per 1024 enables and wraps 63 -> 0.
4. i_en toggling 1-of-3 cycles with a delayed-PRBS input.
   - Lock at the same enable count as scenario 1.
   - Counters unchanged on i_en=0 cycles.
5. CNT_BW=8, locked, clean input.
   - o_bit_cnt sticks at 255 and o_sat=1.
   - i_clear with i_en=1 zeros both counters and o_sat, and that sample is not counted.
6. Assert i_rst for 1 cycle mid-LOCKED.
   - Outputs 0 asynchronously and state returns to FILL.
   - Relock at delay 5 after 64 + 6*1024 enables.
